// File: rtl/logic_func_checker.sv
`default_nettype none
// ============================================================================
// Module      : logic_func_checker
// Description : BIST driver/checker sweeping all 16 vectors of
//               y = (a & b) | (c ^ d) with a programmable settling window.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_func_checker #(
    parameter int LATENCY = 0,
    parameter int PASSES  = 1,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_flag,
    output logic [3:0]       first_fail_vec
);

    localparam int c_win_w = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int c_pas_w = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [c_win_w-1:0] c_win_last  = c_win_w'(LATENCY);
    localparam logic [c_pas_w-1:0] c_pass_last = c_pas_w'(PASSES - 1);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_apply = 2'd1;
    localparam logic [1:0] c_s_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_vec;
    logic [c_win_w-1:0] r_win;
    logic [c_pas_w-1:0] r_pcnt;
    logic [ERR_W-1:0]   r_err;
    logic               r_fail;
    logic [3:0]         r_ffv;
    logic               r_pass;

    logic w_cmp;
    logic w_exp;
    logic w_miss;
    logic w_last;

    assign w_cmp  = (r_state == c_s_apply) && (r_win == c_win_last);
    assign w_exp  = (r_vec[3] & r_vec[2]) | (r_vec[1] ^ r_vec[0]);
    assign w_miss = w_cmp && (y != w_exp);
    assign w_last = w_cmp && (r_vec == 4'hF) && (r_pcnt == c_pass_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle:  if (start) w_next_state = c_s_apply;
            c_s_apply: if (w_last) w_next_state = c_s_done;
            c_s_done:  w_next_state = c_s_idle;
            default:   w_next_state = c_s_idle;
        endcase
    end

    // r_vec is forced back to 0 on the final compare, so it doubles as the
    // idle-time stimulus and a..d stay registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec  <= 4'd0;
            r_win  <= '0;
            r_pcnt <= '0;
            r_err  <= '0;
            r_fail <= 1'b0;
            r_ffv  <= 4'd0;
            r_pass <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_vec  <= 4'd0;
                        r_win  <= '0;
                        r_pcnt <= '0;
                        r_err  <= '0;
                        r_fail <= 1'b0;
                        r_ffv  <= 4'd0;
                        r_pass <= 1'b0;
                    end
                end
                c_s_apply: begin
                    if (!w_cmp) begin
                        r_win <= r_win + 1'b1;
                    end else begin
                        r_win <= '0;
                        if (w_miss) begin
                            if (r_err != {ERR_W{1'b1}}) r_err <= r_err + 1'b1;
                            if (!r_fail) begin
                                r_fail <= 1'b1;
                                r_ffv  <= r_vec;
                            end
                        end
                        if (w_last) begin
                            r_vec  <= 4'd0;
                            r_pass <= ~(r_fail | w_miss);
                        end else begin
                            r_vec <= r_vec + 4'd1;
                            if (r_vec == 4'hF) r_pcnt <= r_pcnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {a, b, c, d}    = r_vec;
    assign busy            = (r_state == c_s_apply);
    assign done            = (r_state == c_s_done);
    assign pass            = r_pass;
    assign err_cnt         = r_err;
    assign fail_flag       = r_fail;
    assign first_fail_vec  = r_ffv;

endmodule
`default_nettype wire
